// File: rtl/pc_seq_ctrl_pkg.sv
// Shared CPU sequencing types: next-PC select encodings, sequencer states and redirect decode.
package pc_seq_ctrl_pkg;

  localparam int unsigned NPC_OP_W = 2;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_SEQ  = 2'd0,
    NPC_IMM  = 2'd1,
    NPC_REG  = 2'd2,
    NPC_TRAP = 2'd3
  } npc_op_e;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_UPDATE = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic br_taken;
    logic jal;
    logic jalr;
  } redir_t;

  // Redirect kind for a completed instruction; traps are prioritised by the caller.
  function automatic npc_op_e redirect_sel(input redir_t r);
    npc_op_e op;
    op = NPC_SEQ;
    if (r.jalr) begin
      op = NPC_REG;
    end else if (r.jal || r.br_taken) begin
      op = NPC_IMM;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Handshake bundle between the PC sequencer and the fetch/execute datapath.
interface pc_seq_ctrl_if #(
  parameter int unsigned CNT_W = 32
);

  logic             imem_ready;
  logic             exec_done;
  logic             br_taken;
  logic             jal;
  logic             jalr;
  logic             trap;
  logic             stall;
  logic             PCwr;
  logic [1:0]       NPCop;
  logic             imem_req;
  logic             inst_valid;
  logic             fetch_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  imem_ready, exec_done, br_taken, jal, jalr, trap, stall,
    output PCwr, NPCop, imem_req, inst_valid, fetch_err, retired
  );

  modport slave (
    output imem_ready, exec_done, br_taken, jal, jalr, trap, stall,
    input  PCwr, NPCop, imem_req, inst_valid, fetch_err, retired
  );

endinterface

// File: rtl/pc_seq_ctrl_fetch_timer.sv
// Fetch wait-cycle counter; expired_c_o flags the TIMEOUT-th enabled wait cycle.
module pc_seq_ctrl_fetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_c_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_c_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = expired_c_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: boot, fetch with timeout, execute, one-cycle PC update with prioritised next-PC select.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_seq_ctrl_if.master        ctl_io
);

  pc_state_e        state_q, state_d;
  npc_op_e          redir_q, redir_d;
  npc_op_e          upd_op;
  logic             pend_q, pend_d;
  logic             pcwr_q, pcwr_d;
  logic             imem_req_q, imem_req_d;
  logic             inst_valid_q, inst_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             trap_eff;
  logic             enter_upd;
  logic             tmr_en, tmr_clr, tmr_expired;
  redir_t           redir_in;

  assign redir_in = {ctl_io.br_taken, ctl_io.jal, ctl_io.jalr};
  assign trap_eff = pend_q || ctl_io.trap;
  assign tmr_en   = (state_q == S_FETCH) && !ctl_io.stall && !trap_eff && !ctl_io.imem_ready;
  assign tmr_clr  = (state_q != S_FETCH);

  pc_seq_ctrl_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (tmr_en),
    .clr_i       (tmr_clr),
    .expired_c_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall freezes every transition; a pending trap beats any normal progress.
  always_comb begin
    state_d   = state_q;
    enter_upd = 1'b0;
    upd_op    = NPC_SEQ;
    if (!ctl_io.stall) begin
      unique case (state_q)
        S_BOOT: state_d = S_FETCH;
        S_FETCH: begin
          if (trap_eff || tmr_expired) begin
            state_d   = S_UPDATE;
            enter_upd = 1'b1;
            upd_op    = NPC_TRAP;
          end else if (ctl_io.imem_ready) begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (trap_eff) begin
            state_d   = S_UPDATE;
            enter_upd = 1'b1;
            upd_op    = NPC_TRAP;
          end else if (ctl_io.exec_done) begin
            state_d   = S_UPDATE;
            enter_upd = 1'b1;
            upd_op    = redirect_sel(redir_in);
          end
        end
        S_UPDATE: state_d = S_FETCH;
        default:  state_d = S_BOOT;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    pend_d       = trap_eff;
    pcwr_d       = enter_upd;
    redir_d      = NPC_SEQ;
    imem_req_d   = (state_d == S_FETCH) && !ctl_io.stall;
    inst_valid_d = (state_q == S_FETCH) && (state_d == S_EXEC);
    fetch_err_d  = fetch_err_q || tmr_expired;
    retired_d    = retired_q + CNT_W'(enter_upd);
    if (enter_upd) begin
      redir_d = upd_op;
      if (upd_op == NPC_TRAP) begin
        pend_d = 1'b0;
      end
    end else if (state_d == S_UPDATE) begin
      redir_d = redir_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q       <= 1'b0;
      redir_q      <= NPC_SEQ;
      pcwr_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      retired_q    <= '0;
    end else begin
      pend_q       <= pend_d;
      redir_q      <= redir_d;
      pcwr_q       <= pcwr_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      retired_q    <= retired_d;
    end
  end

  assign ctl_io.PCwr       = pcwr_q;
  assign ctl_io.NPCop      = redir_q;
  assign ctl_io.imem_req   = imem_req_q;
  assign ctl_io.inst_valid = inst_valid_q;
  assign ctl_io.fetch_err  = fetch_err_q;
  assign ctl_io.retired    = retired_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios plus random stimulus against a phase-level reference model.
module tb_pc_seq_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pc_seq_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_io (bus)
  );

  typedef enum int {P_BOOT, P_WAIT_INST, P_RUN, P_COMMIT} phase_t;

  int     n_cmp = 0;
  int     n_err = 0;
  phase_t phase;
  int     waited;
  bit     trap_pend;
  bit     m_err;
  int     m_retired;
  bit     e_pcwr, e_req, e_valid;
  int     e_npc;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase     = P_BOOT;
    waited    = 0;
    trap_pend = 1'b0;
    m_err     = 1'b0;
    m_retired = 0;
    e_pcwr    = 1'b0;
    e_req     = 1'b0;
    e_valid   = 1'b0;
    e_npc     = 0;
  endtask

  // One clock of the sequencer as seen from outside: what the next cycle should show.
  task automatic model_edge(input bit rdy, input bit done, input bit br, input bit jal,
                            input bit jalr, input bit tr, input bit st);
    bit tq;
    bit commit;
    int kind;
    tq      = trap_pend || tr;
    commit  = 1'b0;
    kind    = 0;
    e_pcwr  = 1'b0;
    e_valid = 1'b0;
    if (st) begin
      trap_pend = tq;
      e_req     = 1'b0;
      return;
    end
    case (phase)
      P_BOOT: begin
        phase  = P_WAIT_INST;
        waited = 0;
      end
      P_WAIT_INST: begin
        if (tq) begin
          commit = 1'b1;
          kind   = 3;
        end else if (rdy) begin
          phase   = P_RUN;
          e_valid = 1'b1;
        end else begin
          waited++;
          if (waited == TIMEOUT) begin
            m_err  = 1'b1;
            commit = 1'b1;
            kind   = 3;
          end
        end
      end
      P_RUN: begin
        if (tq) begin
          commit = 1'b1;
          kind   = 3;
        end else if (done) begin
          commit = 1'b1;
          kind   = jalr ? 2 : ((jal || br) ? 1 : 0);
        end
      end
      default: begin
        phase  = P_WAIT_INST;
        waited = 0;
      end
    endcase
    if (commit) begin
      phase     = P_COMMIT;
      e_pcwr    = 1'b1;
      e_npc     = kind;
      m_retired = (m_retired + 1) % (1 << CNT_W);
      trap_pend = 1'b0;
    end else begin
      trap_pend = tq;
      if (phase != P_COMMIT) e_npc = 0;
    end
    e_req = (phase == P_WAIT_INST);
  endtask

  task automatic check_all();
    check("PCwr",       int'(bus.PCwr),       int'(e_pcwr));
    check("NPCop",      int'(bus.NPCop),      e_npc);
    check("imem_req",   int'(bus.imem_req),   int'(e_req));
    check("inst_valid", int'(bus.inst_valid), int'(e_valid));
    check("fetch_err",  int'(bus.fetch_err),  int'(m_err));
    check("retired",    int'(bus.retired),    m_retired);
  endtask

  task automatic cyc(input bit rdy, input bit done, input bit br, input bit jal,
                     input bit jalr, input bit tr, input bit st);
    bus.imem_ready = rdy;
    bus.exec_done  = done;
    bus.br_taken   = br;
    bus.jal        = jal;
    bus.jalr       = jalr;
    bus.trap       = tr;
    bus.stall      = st;
    @(posedge clk);
    model_edge(rdy, done, br, jal, jalr, tr, st);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    bus.exec_done  = 1'b0;
    bus.br_taken   = 1'b0;
    bus.jal        = 1'b0;
    bus.jalr       = 1'b0;
    bus.trap       = 1'b0;
    bus.stall      = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit slow;
    bit rdy;
    do_reset();

    // Boot, two empty fetch cycles, then a plain sequential instruction.
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("boot_req", int'(bus.imem_req), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("seq_valid", int'(bus.inst_valid), 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("seq_pcwr", int'(bus.PCwr), 1);
    check("seq_npc", int'(bus.NPCop), 0);
    check("seq_ret", int'(bus.retired), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("pcwr_once", int'(bus.PCwr), 0);

    // Branch and jalr together: jalr wins.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0, 0);
    check("jalr_prio", int'(bus.NPCop), 2);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Fetch timeout.
    for (int i = 0; i < int'(TIMEOUT); i++) cyc(0, 0, 0, 0, 0, 0, 0);
    check("to_err", int'(bus.fetch_err), 1);
    check("to_npc", int'(bus.NPCop), 3);
    check("to_pcwr", int'(bus.PCwr), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Stall during execute, then jal.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("stall_out", int'({bus.PCwr, bus.imem_req, bus.inst_valid}), 0);
    end
    cyc(0, 1, 0, 1, 0, 0, 0);
    check("jal_npc", int'(bus.NPCop), 1);
    check("jal_pcwr", int'(bus.PCwr), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Trap during execute, then reset in the update cycle.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("trap_npc", int'(bus.NPCop), 3);
    check("trap_pcwr", int'(bus.PCwr), 1);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_pcwr", int'(bus.PCwr), 0);
    check("rst_ret", int'(bus.retired), 0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    slow = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) slow = ($urandom % 2) == 1;
      if (i % 997 == 500) do_reset();
      rdy = slow ? (($urandom % 40) == 0) : (($urandom % 3) == 0);
      cyc(rdy, ($urandom % 4) == 0, $urandom % 2 == 1, $urandom % 2 == 1,
          $urandom % 3 == 0, ($urandom % 32) == 0, ($urandom % 8) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
